// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if -- bus bundle between the instruction fetch unit, the
// instruction memory, the redirect source and the decoder.
//
//   master : the fetch unit (drives imem_req/imem_addr and the ir_* outputs)
//   slave  : the environment (memory, branch unit, decoder)
//
// Signals
//   imem_req/imem_addr     : read request and word-aligned address
//   imem_gnt               : memory accepts the request this cycle
//   imem_rvalid/imem_rdata : read data return
//   redirect/redirect_pc   : branch/jump redirect strobe and target
//   ir_valid/ir_ready      : instruction handshake towards the decoder
//   ir/pc                  : instruction word and its address
//   cu_op/funct3/funct7    : fixed-position fields of ir
//   misalign               : sticky misaligned-redirect trap, present only
//                            when INST_FETCH_MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [6:0]  cu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output ir_valid,
    input  ir_ready,
    output ir, pc, cu_op, funct3, funct7
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    , output misalign
`endif
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  ir_valid,
    output ir_ready,
    input  ir, pc, cu_op, funct3, funct7
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    , input misalign
`endif
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- single-outstanding-request instruction fetch unit.
//
// Fetches sequential words starting at RESET_PC, presents each one to the
// decoder with a valid/ready handshake, and follows branch/jump redirects.
// A word that was already requested when a redirect arrives is discarded on
// return rather than presented.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   en     : run enable; new fetches start only while high
//   bus    : inst_fetch_if.master (memory, redirect and decoder signals)
//
// Optional feature
//   INST_FETCH_MISALIGN_TRAP_EN : when defined, a redirect whose target is not
//   word-aligned raises the sticky bus.misalign flag and halts fetching until
//   reset. When undefined, redirect_pc[1:0] is ignored.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  inst_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_drop;

  logic [31:0] w_redirect_pc;
  logic        w_blocked;
  logic        w_rsp;
  logic        w_drop_now;
  logic        w_accept;

`ifdef INST_FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign_evt;

  assign w_redirect_pc  = bus.redirect_pc;
  assign w_misalign_evt = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  // Block in the same cycle the bad redirect is seen, and forever after.
  assign w_blocked      = r_misalign | w_misalign_evt;
  assign bus.misalign   = r_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n)              r_misalign <= 1'b0;
    else if (w_misalign_evt) r_misalign <= 1'b1;
  end
`else
  // Low address bits are forced to zero so a target is always word-aligned.
  assign w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;
  assign w_blocked     = 1'b0;
`endif

  // A return in WAIT is discarded if a redirect is pending or arrives now:
  // the word belongs to the old instruction stream either way.
  assign w_rsp      = (r_state == WAIT) && bus.imem_rvalid;
  assign w_drop_now = r_drop | bus.redirect;
  assign w_accept   = w_rsp && !w_drop_now;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so every path assigns w_next_state and no latch
    // is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (en) w_next_state = REQ;
      // An issued request is always completed, even if en has dropped.
      REQ:   if (bus.imem_gnt) w_next_state = WAIT;
      WAIT:  if (bus.imem_rvalid) begin
               if (w_drop_now) w_next_state = en ? REQ : IDLE;
               else            w_next_state = VALID;
             end
      // A redirect squashes the presented word even when ir_ready is high.
      VALID: if (bus.redirect || bus.ir_ready) w_next_state = en ? REQ : IDLE;
    endcase
    if (w_blocked) w_next_state = IDLE;
  end

  // Output logic.
  always_comb begin
    bus.imem_req = (r_state == REQ);
    bus.ir_valid = (r_state == VALID);
  end

  assign bus.imem_addr = r_fetch_pc;
  assign bus.ir        = r_ir;
  assign bus.pc        = r_pc;
  assign bus.cu_op     = r_ir[6:0];
  assign bus.funct3    = r_ir[14:12];
  assign bus.funct7    = r_ir[31:25];

  // Datapath: fetch address, instruction register and the drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_pc       <= '0;
      r_ir       <= NOP;
      r_drop     <= 1'b0;
    end else begin
      // Redirect wins over the sequential increment; the +4 wraps mod 2^32.
      if (bus.redirect)  r_fetch_pc <= w_redirect_pc;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_accept) begin
        r_ir <= bus.imem_rdata;
        r_pc <= r_fetch_pc;
      end

      // Drop is armed only when a request is already (or just) granted.
      if (w_rsp)
        r_drop <= 1'b0;
      else if (bus.redirect &&
               ((r_state == WAIT) || ((r_state == REQ) && bus.imem_gnt)))
        r_drop <= 1'b1;
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: en  input  1  run enable; new fetches start only while high.
REQ-005 SHALL have port: imem_req  output  1  instruction memory read request.
REQ-006 SHALL have port: imem_addr  output  32  request address, word-aligned.
REQ-007 SHALL have port: imem_gnt  input  1  memory accepts request this cycle.
REQ-008 SHALL have port: imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port: imem_rdata  input  32  read data.
REQ-010 SHALL have port: redirect  input  1  branch/jump redirect strobe.
REQ-011 SHALL have port: redirect_pc  input  32  redirect target.
REQ-012 SHALL have port: ir_valid  output  1  instruction presented to decoder.
REQ-013 SHALL have port: ir_ready  input  1  decoder consumes instruction.
REQ-014 SHALL have port: ir  output  32  instruction word.
REQ-015 SHALL have port: pc  output  32  address of ir.
REQ-016 SHALL have ports: cu_op output 7 = ir[6:0]; funct3 output 3 = ir[14:12]; funct7 output 7 = ir[31:25]; combinational slices of registered ir.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, VALID; one outstanding memory request maximum.
REQ-018 SHALL in IDLE: imem_req=0, ir_valid=0; en=1 -> REQ.
REQ-019 SHALL in REQ: imem_req=1, imem_addr=fetch_pc (internal register); imem_gnt=1 -> WAIT; else hold REQ with address stable.
REQ-020 SHALL in WAIT: imem_req=0; imem_rvalid=1 -> ir<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, -> VALID.
REQ-021 SHALL in VALID: ir_valid=1, ir/pc stable; ir_ready=1 -> REQ if en=1, else IDLE; ir_ready=0 -> hold.
REQ-022 SHALL achieve minimum latency: REQ cycle with gnt=1, rvalid next cycle, ir_valid asserted the cycle after (2 cycles REQ-entry to ir_valid).
REQ-023 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-024 SHALL on redirect=1: fetch_pc<=redirect_pc in any state; redirect has priority over the sequential increment.
REQ-025 SHALL on redirect in VALID: drop ir_valid next cycle (squash, even if ir_ready=1 same cycle -- the instruction counts as consumed) and go to REQ.
REQ-026 SHALL on redirect in WAIT, or in REQ with imem_gnt=1: set drop flag; discard the following rvalid data (ir/pc unchanged), then -> REQ at the new fetch_pc.
REQ-027 SHALL on redirect in IDLE or REQ without gnt: update fetch_pc only; a pending REQ re-issues with the new address next cycle.
REQ-028 SHALL ignore imem_rvalid outside WAIT.
REQ-029 SHALL on en=0: finish any in-flight request and hold the result in VALID; no new request issued.

Reset
REQ-030 SHALL on rst_n=0 at clk edge: state=IDLE, fetch_pc=RESET_PC, pc=0, ir=32'h0000_0013 (NOP), ir_valid=0, imem_req=0, drop flag=0.
REQ-031 SHALL abort any in-flight request on reset; a late rvalid after reset is ignored (state not WAIT).

Configuration
REQ-032 SHALL support macro INST_FETCH_MISALIGN_TRAP_EN.
REQ-033 SHALL with the macro defined: add port misalign output 1; redirect with redirect_pc[1:0]!=0 sets sticky misalign=1 (reset 0), forces IDLE, blocks all fetches until reset.
REQ-034 SHALL without the macro: no misalign port; redirect_pc[1:0] ignored (treated as 00).

Verification
REQ-035 SHALL cover: reset, en=1, gnt and rvalid immediate, rdata=32'h00500093 -> ir_valid 2 cycles after REQ, pc=0, cu_op=7'b0010011, next imem_addr=4.
REQ-036 SHALL cover: ir_ready held 0 for 5 cycles -> ir/pc stable, imem_req=0 throughout.
REQ-037 SHALL cover: redirect to 32'h100 while WAIT -> returned word discarded, next imem_addr=32'h100, delivered pc=32'h100.
REQ-038 SHALL cover: fetch_pc=32'hFFFF_FFFC delivered -> next imem_addr=32'h0.
REQ-039 SHALL cover: rst_n=0 mid-WAIT, then rvalid=1 -> ir_valid stays 0, ir=32'h00000013, next request at RESET_PC.
REQ-040 SHALL cover (macro on): redirect_pc=32'h102 -> misalign=1, imem_req stays 0 until reset.
